pl_stage: RTL and testbench



---
 rtl/pl_stage.sv | 114 +++++++++++
 tb/tb_pl_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pl_stage.sv
// Pipeline stage register with valid/ready handshake, flush and a saturating stall counter.
// Define PL_STAGE_SKID_EN to add a one-entry skid register that registers up_ready.
module pl_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  input  logic              flush_in,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid_reg, main_valid_next;
  logic [DATA_W-1:0] main_data_reg, main_data_next;
  logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
  logic              up_xfer;
  logic              main_load;

  // Main register may take a new payload when empty or when its payload leaves now.
  assign main_load = ~main_valid_reg | dn_ready;
  assign up_xfer   = up_valid & up_ready;

`ifdef PL_STAGE_SKID_EN
  logic              skid_valid_reg, skid_valid_next;
  logic [DATA_W-1:0] skid_data_reg, skid_data_next;

  assign up_ready = ~skid_valid_reg;

  always_comb begin
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    if (flush_in) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (main_load) begin
      if (skid_valid_reg) begin
        // Older skid payload moves forward; skid refills from upstream if accepted.
        main_valid_next = 1'b1;
        main_data_next  = skid_data_reg;
        skid_valid_next = up_xfer;
        if (up_xfer) begin
          skid_data_next = up_data;
        end
      end else begin
        main_valid_next = up_xfer;
        if (up_xfer) begin
          main_data_next = up_data;
        end
      end
    end else if (up_xfer) begin
      skid_valid_next = 1'b1;
      skid_data_next  = up_data;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
    end else begin
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
    end
  end
`else
  assign up_ready = main_load;

  always_comb begin
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    if (flush_in) begin
      main_valid_next = 1'b0;
    end else if (main_load) begin
      main_valid_next = up_xfer;
      if (up_xfer) begin
        main_data_next = up_data;
      end
    end
  end
`endif

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (main_valid_reg && !dn_ready && !(&stall_cnt_reg)) begin
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    end
  end

  // Data is reset too so dn_data is never X, and is only rewritten on a real load.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      main_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      stall_cnt_reg  <= '0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_data_reg  <= main_data_next;
      stall_cnt_reg  <= stall_cnt_next;
    end
  end

  assign dn_valid  = main_valid_reg;
  assign dn_data   = main_data_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pl_stage.sv
// Self-checking bench for pl_stage: directed vector table, async reset, saturation, random vs queue model.
module tb_pl_stage;

`ifdef PL_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        up_valid, up_ready, dn_valid, dn_ready, flush_in;
  logic [31:0] up_data, dn_data;
  logic [15:0] stall_cnt;

  logic        s_up_valid, s_up_ready, s_dn_valid, s_dn_ready, s_flush;
  logic [7:0]  s_up_data, s_dn_data;
  logic [3:0]  s_stall_cnt;

  always #5 clk_in = ~clk_in;

  pl_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
    .flush_in(flush_in), .stall_cnt(stall_cnt)
  );

  pl_stage #(.DATA_W(8), .CNT_W(4)) dut_sat (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .up_valid(s_up_valid), .up_ready(s_up_ready), .up_data(s_up_data),
    .dn_valid(s_dn_valid), .dn_ready(s_dn_ready), .dn_data(s_dn_data),
    .flush_in(s_flush), .stall_cnt(s_stall_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        uv;
    logic [31:0] d;
    logic        dr;
    logic        fl;
    logic        eur;   // up_ready before the edge
    logic        edv;   // dn_valid after the edge
    logic [31:0] edd;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vecs [16];

  // Queue-based reference: the stage is a FIFO of capacity 1 (or 2 with skid).
  logic [31:0] q[$];
  logic [31:0] shown;
  int unsigned mcnt;
  int          pops_model, pops_dut;

  initial begin
    rst_n_in = 1'b0;
    up_valid = 0; up_data = 0; dn_ready = 0; flush_in = 0;
    s_up_valid = 0; s_up_data = 0; s_dn_ready = 0; s_flush = 0;

    // Streaming
    vecs[0]  = '{1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 16'd0};
    vecs[1]  = '{1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22, 16'd0};
    vecs[2]  = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 1'b1, 32'h33, 16'd0};
    vecs[3]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h33, 16'd0};
    // Backpressure: upstream keeps presenting its oldest unaccepted payload
    vecs[4]  = '{1'b1, 32'hA0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA0, 16'd0};
    vecs[5]  = '{1'b1, 32'hA1, 1'b0, 1'b0, SKID, 1'b1, 32'hA0, 16'd1};
    vecs[6]  = '{1'b1, (SKID ? 32'hA2 : 32'hA1), 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0, 16'd2};
    vecs[7]  = '{1'b1, (SKID ? 32'hA2 : 32'hA1), 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0, 16'd3};
    vecs[8]  = '{1'b1, (SKID ? 32'hA2 : 32'hA1), 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0, 16'd4};
    vecs[9]  = '{1'b1, (SKID ? 32'hA2 : 32'hA1), 1'b1, 1'b0, ~SKID, 1'b1, 32'hA1, 16'd4};
    vecs[10] = '{1'b1, 32'hA2, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA2, 16'd4};
    vecs[11] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA2, 16'd4};
    // Flush with the stage full; 0xFF must never appear
    vecs[12] = '{1'b1, 32'hB1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hB1, 16'd4};
    vecs[13] = '{1'b1, 32'hB2, 1'b0, 1'b0, SKID, 1'b1, 32'hB1, 16'd5};
    vecs[14] = '{1'b1, 32'hFF, 1'b1, 1'b1, ~SKID, 1'b0, 32'hB1, 16'd5};
    vecs[15] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'hB1, 16'd5};

    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_dn_valid", {31'd0, dn_valid}, 32'd0);
    chk("rst_dn_data", dn_data, 32'd0);
    chk("rst_up_ready", {31'd0, up_ready}, 32'd1);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    #1 rst_n_in = 1'b1;

    for (int i = 0; i < 16; i++) begin
      up_valid = vecs[i].uv; up_data = vecs[i].d;
      dn_ready = vecs[i].dr; flush_in = vecs[i].fl;
      #1;
      chk($sformatf("vec%0d_up_ready", i), {31'd0, up_ready}, {31'd0, vecs[i].eur});
      @(posedge clk_in); #1;
      chk($sformatf("vec%0d_dn_valid", i), {31'd0, dn_valid}, {31'd0, vecs[i].edv});
      chk($sformatf("vec%0d_dn_data", i), dn_data, vecs[i].edd);
      chk($sformatf("vec%0d_stall_cnt", i), {16'd0, stall_cnt}, {16'd0, vecs[i].ecnt});
      $display("vec %0d uv=%0b d=%08h dr=%0b fl=%0b -> dv=%0b dd=%08h cnt=%0d",
               i, vecs[i].uv, vecs[i].d, vecs[i].dr, vecs[i].fl, dn_valid, dn_data, stall_cnt);
    end

    // Asynchronous reset in the middle of a cycle while holding a payload
    up_valid = 1; up_data = 32'hC5; dn_ready = 0; flush_in = 0;
    @(posedge clk_in); #1;
    up_valid = 0;
    chk("pre_reset_dn_data", dn_data, 32'hC5);
    rst_n_in = 1'b0;
    #1;
    chk("async_rst_dn_valid", {31'd0, dn_valid}, 32'd0);
    chk("async_rst_dn_data", dn_data, 32'd0);
    chk("async_rst_up_ready", {31'd0, up_ready}, 32'd1);
    chk("async_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    $display("async reset: dv=%0b dd=%08h ur=%0b cnt=%0d", dn_valid, dn_data, up_ready, stall_cnt);
    #1 rst_n_in = 1'b1;
    dn_ready = 1;

    // Saturation on the 4-bit counter instance
    s_up_valid = 1; s_up_data = 8'h5A; s_dn_ready = 0;
    @(posedge clk_in); #1;
    s_up_valid = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_in); #1;
      if (k == 14) chk("sat_cnt_14", {28'd0, s_stall_cnt}, 32'd14);
      if (k == 15) chk("sat_cnt_15", {28'd0, s_stall_cnt}, 32'd15);
      if (k == 20) chk("sat_cnt_20", {28'd0, s_stall_cnt}, 32'd15);
    end
    chk("sat_dn_data", {24'd0, s_dn_data}, 32'h5A);
    $display("saturation: cnt=%0d dv=%0b", s_stall_cnt, s_dn_valid);

    // Random traffic against the queue model
    q.delete();
    shown = 32'd0; mcnt = 0; pops_model = 0; pops_dut = 0;
    for (int c = 0; c < 10000; c++) begin
      bit m_ur, m_dnx;
      up_valid = ($urandom_range(0, 3) != 0);
      up_data  = $urandom;
      dn_ready = ($urandom_range(0, 1) != 0);
      flush_in = ($urandom_range(0, 49) == 0);
      m_ur = SKID ? (q.size() < 2) : (q.size() == 0 || dn_ready);
      m_dnx = (q.size() > 0) && dn_ready;
      #1;
      chk("rnd_up_ready", {31'd0, up_ready}, {31'd0, m_ur});
      if (dn_valid && dn_ready) begin
        pops_dut++;
        $display("xfer %0d data=%08h", pops_dut, dn_data);
      end
      if (q.size() > 0 && !dn_ready && mcnt < 65535) mcnt++;
      if (m_dnx) begin
        void'(q.pop_front());
        pops_model++;
      end
      if (flush_in) q.delete();
      else if (up_valid && m_ur) q.push_back(up_data);
      if (!flush_in && q.size() > 0) shown = q[0];
      @(posedge clk_in); #1;
      chk("rnd_dn_valid", {31'd0, dn_valid}, {31'd0, (q.size() > 0)});
      chk("rnd_dn_data", dn_data, shown);
      chk("rnd_stall_cnt", {16'd0, stall_cnt}, mcnt);
    end
    chk("rnd_xfer_count", pops_dut, pops_model);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
